mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide functional unit of the execute stage. Accepts one MULT/MULTU/DIV/DIVU micro-op from issue, computes the 64-bit {HI, LO} result and presents it, with its ROB tag, to the packing logic that fills the mult_commit_t slot of execute_data_t. Multiply has fixed pipelined latency; divide is an iterative radix-2 restoring divider. The unit is non-pipelined: one operation in flight.

## Interface
- DATA_W, 32, operand width; divide iterations = DATA_W.
- TAG_W, 6, ROB tag width.
- MUL_LAT, 2, multiply latency in clock edges (≥1).
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush (mispredict/exception); synchronous, highest priority.
- in_valid  in  1  issue holds a valid op.
- in_ready  out  1  unit can accept; combinational, = (state==IDLE).
- in_op  in  2  mdu_op_t: MULT, MULTU, DIV, DIVU.
- in_src_a / in_src_b  in  DATA_W  rs / rt.
- in_tag  in  TAG_W  ROB tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_hi / out_lo  out  DATA_W  result (remainder/quotient for divide).
- out_tag  out  TAG_W  tag of the result.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset: state IDLE, out_valid 0, out_hi/out_lo/out_tag 0, counter 0.
- IDLE: accept on in_valid && in_ready (and !flush); register op, operands, tag; go MUL or DIV.
- MUL: signed (MULT) or unsigned (MULTU) 64-bit product; counter runs MUL_LAT−1 further edges; result written to out_hi/out_lo at final edge, go DONE.
- DIV: operands converted to magnitudes at accept; DATA_W restoring iterations, one per edge; on the edge after the last iteration apply sign fix (quotient negated if signs differ, remainder takes dividend sign) into out_hi/out_lo, go DONE. DIVU skips sign handling.
- Divide by zero: lo = all ones, hi = in_src_a, both DIV and DIVU. 0x8000_0000 / −1 (DIV): lo = 0x8000_0000, hi = 0.
- DONE: out_valid=1; outputs stable until out_valid && out_ready, then IDLE. No new accept in DONE.
- flush in any state: next state IDLE, out_valid 0, in-flight result discarded; op presented with flush in the same cycle is not accepted.
- Reset mid-operation: immediate IDLE, all outputs to reset values.

## Timing
- Accept at edge e0. MUL: out_valid high after edge e0+MUL_LAT (2 with defaults).
- DIV/DIVU: out_valid high after edge e0+DATA_W+1 (33).
- in_ready low from the cycle after accept until the cycle after the output handshake; throughput one op per latency+1 cycles with out_ready held high.
- out_ready held low: DONE held indefinitely, outputs unchanged.

## Configuration
- MDU_DIV_SHORTCUT_EN defined: in DIV state, if divisor ≠ 0 and |a| < |b| (unsigned magnitudes for DIVU), result lo=0, hi=original in_src_a, written at e0+1; out_valid high after e0+1.
- Undefined: every divide takes the full DATA_W+1 latency; results identical.

## Structure
- execute_pkg gains mdu_op_t enum and default MUL_LAT constant; result tag type shared with mult_commit_t.
- Sub-module div_radix2: iterative divider core (start, magnitudes, signedness in; done, quotient, remainder out). Multiplier stays inline (retimed `*` over MUL_LAT registers).

## Test plan
- MULT 0xFFFF_FFFF × 0x0000_0002 -> hi 0xFFFF_FFFF, lo 0xFFFF_FFFE, out_valid 2 cycles after accept; MULTU same operands -> hi 0x0000_0001, lo 0xFFFF_FFFE.
- DIV 0xFFFF_FFF9 ÷ 0x2 -> lo 0xFFFF_FFFD, hi 0xFFFF_FFFF after 33 cycles; DIVU same -> lo 0x7FFF_FFFC, hi 0x1.
- DIV by 0 with a=0x1234 -> lo 0xFFFF_FFFF, hi 0x1234; DIV 0x8000_0000 ÷ 0xFFFF_FFFF -> lo 0x8000_0000, hi 0.
- out_ready low for 10 cycles in DONE -> out_valid, out_hi/lo/tag stable, in_ready 0; accepted on first out_ready cycle, IDLE next.
- flush at iteration 15 of DIV -> out_valid never rises, in_ready 1 next cycle; flush coincident with in_valid in IDLE -> op not accepted.
- MDU_DIV_SHORTCUT_EN: DIVU 3 ÷ 7 -> lo 0, hi 3, out_valid 1 cycle after accept; without macro, same result after 33.

Source files
------------

// File: rtl/execute_pkg.sv
`default_nettype none
// ============================================================================
// Module      : execute_pkg
// Description : Shared execute-stage types: multiply/divide micro-op encoding,
//               default multiply latency, ROB tag type and the mult_commit_t
//               slot filled from mult_div_unit results.
// Revision    : 1.0 - initial release
// ============================================================================
package execute_pkg;

    localparam int c_rob_tag_w       = 6;
    localparam int c_mul_lat_default = 2;

    typedef logic [c_rob_tag_w-1:0] rob_tag_t;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_t;

    typedef struct packed {
        logic        valid;
        rob_tag_t    tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } mult_commit_t;

    function automatic logic mdu_is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_radix2.sv
`default_nettype none
// ============================================================================
// Module      : div_radix2
// Description : Iterative radix-2 restoring divider core, one quotient bit
//               per clock. Operates on magnitudes; the sign of quotient and
//               remainder is applied on the outputs from the latched flags.
// Ports       : clk, resetn (async active-low), clear (sync abort),
//               start (load operands), dividend/divisor (magnitudes),
//               neg_quo/neg_rem (negate results), done (one-cycle pulse
//               after the last iteration), quotient/remainder (signed-fixed).
// Revision    : 1.0 - initial release
// ============================================================================
module div_radix2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              neg_quo,
    input  logic              neg_rem,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int                c_cnt_w  = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(DATA_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_1  = c_cnt_w'(1);
    localparam logic [DATA_W-1:0]  c_one    = DATA_W'(1);

    logic [DATA_W-1:0]  r_quo;
    logic [DATA_W-1:0]  r_rem;
    logic [DATA_W-1:0]  r_div;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_neg_quo;
    logic               r_neg_rem;

    logic [DATA_W:0]    w_shift;
    logic [DATA_W:0]    w_diff;
    logic               w_fits;

    // Partial remainder shifted left with the next dividend bit; the dividend
    // is consumed MSB-first out of the quotient register as bits shift in.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_fits  = ~w_diff[DATA_W];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_quo     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (clear) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_quo     <= dividend;
            r_rem     <= '0;
            r_div     <= divisor;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_neg_quo <= neg_quo;
            r_neg_rem <= neg_rem;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_rem <= w_fits ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
                r_quo <= {r_quo[DATA_W-2:0], w_fits};
                r_cnt <= r_cnt + c_cnt_1;
                if (r_cnt == c_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done      = r_done;
    assign quotient  = r_neg_quo ? (~r_quo + c_one) : r_quo;
    assign remainder = r_neg_rem ? (~r_rem + c_one) : r_rem;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Non-pipelined multiply/divide unit (MULT/MULTU/DIV/DIVU).
//               Multiply has MUL_LAT edges of latency; divide runs DATA_W
//               restoring iterations plus one sign-fix edge.
// Ports       : clk, resetn (async active-low), flush (sync, highest prio),
//               in_valid/in_ready/in_op/in_src_a/in_src_b/in_tag (issue),
//               out_valid/out_ready/out_hi/out_lo/out_tag (result).
// Config      : MDU_DIV_SHORTCUT_EN - finish a divide one edge after accept
//               when |dividend| < |divisor| (divisor non-zero).
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import execute_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = c_rob_tag_w,
    parameter int MUL_LAT = c_mul_lat_default
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src_a,
    input  logic [DATA_W-1:0] in_src_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_hi,
    output logic [DATA_W-1:0] out_lo,
    output logic [TAG_W-1:0]  out_tag
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam int                  c_mcnt_w   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [c_mcnt_w-1:0] c_mul_last = c_mcnt_w'(MUL_LAT - 1);
    localparam logic [c_mcnt_w-1:0] c_mcnt_1   = c_mcnt_w'(1);
    localparam logic [DATA_W-1:0]   c_one      = DATA_W'(1);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    mdu_op_t             r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [TAG_W-1:0]    r_tag;
    logic [c_mcnt_w-1:0] r_cnt;
    logic [DATA_W-1:0]   r_out_hi;
    logic [DATA_W-1:0]   r_out_lo;
    logic [TAG_W-1:0]    r_out_tag;

    mdu_op_t             w_in_op;
    logic                w_in_signed;
    logic                w_accept;
    logic [DATA_W-1:0]   w_in_mag_a;
    logic [DATA_W-1:0]   w_in_mag_b;
    logic                w_r_signed;
    logic [2*DATA_W-1:0] w_ext_a;
    logic [2*DATA_W-1:0] w_ext_b;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_div_done;
    logic [DATA_W-1:0]   w_div_quo;
    logic [DATA_W-1:0]   w_div_rem;
    logic                w_shortcut;
    logic                w_mul_last;
    logic                w_result_we;
    logic [DATA_W-1:0]   w_res_hi;
    logic [DATA_W-1:0]   w_res_lo;

    assign w_in_op     = mdu_op_t'(in_op);
    assign w_in_signed = mdu_is_signed(w_in_op);
    assign w_accept    = in_valid && (r_state == c_st_idle) && !flush;

    // Magnitudes are formed at accept so the divider core starts on e0.
    assign w_in_mag_a = (w_in_signed && in_src_a[DATA_W-1]) ? (~in_src_a + c_one) : in_src_a;
    assign w_in_mag_b = (w_in_signed && in_src_b[DATA_W-1]) ? (~in_src_b + c_one) : in_src_b;

    // Extending both operands to 2*DATA_W makes the low half of a plain
    // product the exact signed/unsigned result; retiming spreads the multiplier
    // across the MUL_LAT cycles the operands are held.
    assign w_r_signed = mdu_is_signed(r_op);
    assign w_ext_a    = {{DATA_W{w_r_signed & r_a[DATA_W-1]}}, r_a};
    assign w_ext_b    = {{DATA_W{w_r_signed & r_b[DATA_W-1]}}, r_b};
    assign w_prod     = w_ext_a * w_ext_b;

    div_radix2 #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (flush),
        .start     (w_accept && mdu_is_div(w_in_op)),
        .dividend  (w_in_mag_a),
        .divisor   (w_in_mag_b),
        .neg_quo   (w_in_signed && (in_src_a[DATA_W-1] ^ in_src_b[DATA_W-1])),
        .neg_rem   (w_in_signed && in_src_a[DATA_W-1]),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

`ifdef MDU_DIV_SHORTCUT_EN
    logic [DATA_W-1:0] w_mag_a;
    logic [DATA_W-1:0] w_mag_b;
    assign w_mag_a    = (w_r_signed && r_a[DATA_W-1]) ? (~r_a + c_one) : r_a;
    assign w_mag_b    = (w_r_signed && r_b[DATA_W-1]) ? (~r_b + c_one) : r_b;
    assign w_shortcut = (r_b != '0) && (w_mag_a < w_mag_b);
`else
    assign w_shortcut = 1'b0;
`endif

    assign w_mul_last  = (r_cnt == c_mul_last);
    assign w_result_we = !flush &&
                         (((r_state == c_st_mul) && w_mul_last) ||
                          ((r_state == c_st_div) && (w_shortcut || w_div_done)));

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= c_st_idle;
        else         r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (w_accept)
                           w_next_state = mdu_is_div(w_in_op) ? c_st_div : c_st_mul;
            c_st_mul:  if (w_mul_last)                w_next_state = c_st_done;
            c_st_div:  if (w_shortcut || w_div_done)  w_next_state = c_st_done;
            c_st_done: if (out_ready)                 w_next_state = c_st_idle;
            default:                                  w_next_state = c_st_idle;
        endcase
        if (flush) w_next_state = c_st_idle;
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == c_st_idle);
        out_valid = (r_state == c_st_done);
    end

    // Result selection; divide-by-zero and the shortcut override the core.
    always_comb begin
        w_res_hi = w_div_rem;
        w_res_lo = w_div_quo;
        if (r_state == c_st_mul) begin
            w_res_hi = w_prod[2*DATA_W-1:DATA_W];
            w_res_lo = w_prod[DATA_W-1:0];
        end else if (r_b == '0) begin
            w_res_hi = r_a;
            w_res_lo = '1;
        end else if (w_shortcut) begin
            w_res_hi = r_a;
            w_res_lo = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op      <= MDU_MULT;
            r_a       <= '0;
            r_b       <= '0;
            r_tag     <= '0;
            r_cnt     <= '0;
            r_out_hi  <= '0;
            r_out_lo  <= '0;
            r_out_tag <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= w_in_op;
                r_a   <= in_src_a;
                r_b   <= in_src_b;
                r_tag <= in_tag;
                r_cnt <= '0;
            end else if ((r_state == c_st_mul) && !w_mul_last) begin
                r_cnt <= r_cnt + c_mcnt_1;
            end
            if (w_result_we) begin
                r_out_hi  <= w_res_hi;
                r_out_lo  <= w_res_lo;
                r_out_tag <= r_tag;
            end
        end
    end

    assign out_hi  = r_out_hi;
    assign out_lo  = r_out_lo;
    assign out_tag = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed/random self-checking bench for mult_div_unit with a
//               scoreboard queue of expected results and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    import execute_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'd0;
    logic [31:0] in_src_a = '0;
    logic [31:0] in_src_b = '0;
    logic [5:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic [5:0]  out_tag;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [5:0]  tag;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_src_a  (in_src_a),
        .in_src_b  (in_src_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hi    (out_hi),
        .out_lo    (out_lo),
        .out_tag   (out_tag)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

    // Reference result {hi, lo} built from native SV arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              q, r;
        case (op)
            2'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            2'd1: begin
                ua = {32'h0, a};
                ub = {32'h0, b};
                return 64'(ua * ub);
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (op == 2'd2) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    return {r, q};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[1] == 1'b0) return 2;
`ifdef MDU_DIV_SHORTCUT_EN
        if (b != 32'h0 && mag(a, op == 2'd2) < mag(b, op == 2'd2)) return 1;
`endif
        return 33;
    endfunction

    // Issue one op, wait for its result, compare against the scoreboard head.
    // hold: keep out_ready low for 10 cycles in DONE before accepting.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] tag, input logic [63:0] fixed, input logic use_fixed,
                          input logic hold);
        exp_t        e;
        logic [63:0] r;
        int          cycles;
        r = use_fixed ? fixed : model(op, a, b);
        @(negedge clk);
        check("ready_before_issue", 64'(in_ready), 64'd1);
        out_ready = !hold;
        in_valid  = 1'b1;
        in_op     = op;
        in_src_a  = a;
        in_src_b  = b;
        in_tag    = tag;
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.tag = tag;
        e.lat = exp_lat(op, a, b);
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        check("ready_low_busy", 64'(in_ready), 64'd0);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        if (sb_q.size() > 0) e = sb_q.pop_front();
        check("latency", 64'(cycles), 64'(e.lat));
        check("hi", 64'(out_hi), 64'(e.hi));
        check("lo", 64'(out_lo), 64'(e.lo));
        check("tag", 64'(out_tag), 64'(e.tag));
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("hold_valid_ready", 64'({out_valid, in_ready}), 64'b10);
                check("hold_data", {out_hi, out_lo}, {e.hi, e.lo});
                check("hold_tag", 64'(out_tag), 64'(e.tag));
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("idle_after_handshake", 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        int          saw;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        // Reset
        repeat (3) @(negedge clk);
        check("reset_outputs", {out_hi, out_lo}, 64'h0);
        check("reset_flags", 64'({out_valid, in_ready, out_tag}), 64'({1'b0, 1'b1, 6'h0}));
        resetn = 1'b1;

        // Multiply
        run_op(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 6'h01, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 1'b1, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 6'h02, {32'h0000_0001, 32'hFFFF_FFFE}, 1'b1, 1'b0);
        run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 6'h03, 64'h0, 1'b0, 1'b0);

        // Divide
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 6'h04, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1, 1'b0);
        run_op(2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 6'h05, {32'h0000_0001, 32'h7FFF_FFFC}, 1'b1, 1'b0);
        run_op(2'd2, 32'h0000_1234, 32'h0000_0000, 6'h06, {32'h0000_1234, 32'hFFFF_FFFF}, 1'b1, 1'b0);
        run_op(2'd3, 32'h8765_4321, 32'h0000_0000, 6'h07, {32'h8765_4321, 32'hFFFF_FFFF}, 1'b1, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6'h08, {32'h0000_0000, 32'h8000_0000}, 1'b1, 1'b0);
        run_op(2'd3, 32'h0000_0003, 32'h0000_0007, 6'h09, {32'h0000_0003, 32'h0000_0000}, 1'b1, 1'b0);
        run_op(2'd2, 32'hFFFF_FFFD, 32'h0000_0007, 6'h0A, {32'hFFFF_FFFD, 32'h0000_0000}, 1'b1, 1'b0);

        // Back-pressure in DONE
        run_op(2'd2, 32'h0000_0064, 32'hFFFF_FFF9, 6'h2A, 64'h0, 1'b0, 1'b1);
        run_op(2'd1, 32'hDEAD_BEEF, 32'h0000_1000, 6'h2B, 64'h0, 1'b0, 1'b1);

        // Flush during divide iteration 15
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'd2; in_src_a = 32'h0000_1000; in_src_b = 32'h3; in_tag = 6'h11;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_div_idle", 64'({out_valid, in_ready}), 64'b01);
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) saw++;
        end
        check("flush_div_no_valid", 64'(saw), 64'd0);

        // Flush coincident with an issue in IDLE
        in_valid = 1'b1; in_op = 2'd0; in_src_a = 32'h5; in_src_b = 32'h6; in_tag = 6'h12;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_issue_not_taken", 64'(in_ready), 64'd1);
        saw = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) saw++;
        end
        check("flush_issue_no_valid", 64'(saw), 64'd0);

        // Reset in the middle of a divide
        in_valid = 1'b1; in_op = 2'd3; in_src_a = 32'hFFFF_0000; in_src_b = 32'h7; in_tag = 6'h13;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midreset_data", {out_hi, out_lo}, 64'h0);
        check("midreset_flags", 64'({out_valid, in_ready, out_tag}), 64'({1'b0, 1'b1, 6'h0}));
        @(negedge clk);
        resetn = 1'b1;

        // Random mix
        for (int k = 0; k < 8; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (k % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            run_op(rop, ra, rb, 6'(k + 32), 64'h0, 1'b0, 1'b0);
        end

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
